unidade_controle: RTL and testbench

Multicycle control unit for the 8-bit processor. It fetches instructions and immediates from instruction memory over a request/acknowledge handshake, decodes them, and drives the register-file addresses, write strobe, write-data select and the 3-bit `sinal_ula` operation code of the ALU. It sits directly upstream of the ALU: `sinal_ula` goes straight to the ALU; `reg_rd` and `reg_rs` select the register-file words that become `entrada1` and `entrada2`.

---
 rtl/unidade_controle_if.sv | 22 ++
 rtl/unidade_controle.sv | 128 ++++++++++++
 tb/tb_unidade_controle.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unidade_controle_if.sv
// Instruction-memory fetch handshake between the control unit and memory.
// The control unit is the master: it raises the request, memory acknowledges.
interface unidade_controle_if;
    logic       mem_req;
    logic [7:0] mem_endereco;
    logic       mem_ack;
    logic [7:0] mem_dado;

    modport master (
        output mem_req,
        output mem_endereco,
        input  mem_ack,
        input  mem_dado
    );

    modport slave (
        input  mem_req,
        input  mem_endereco,
        output mem_ack,
        output mem_dado
    );
endinterface

// File: rtl/unidade_controle.sv
// Multicycle control unit for the 8-bit processor: fetch, decode,
// execute and register write-back sequencing, with LI immediates and HALT.
module unidade_controle (
    input  logic                       clock,
    input  logic                       reset_n,
    unidade_controle_if.master         bus,
    output logic [2:0]                 sinal_ula,
    output logic [1:0]                 reg_rd,
    output logic [1:0]                 reg_rs,
    output logic                       reg_escrita,
    output logic                       sel_imediato,
    output logic [7:0]                 imediato,
    output logic [7:0]                 pc,
    output logic                       parado
);

    typedef enum logic [2:0] {
        INICIO,
        BUSCA,
        DECODIFICA,
        EXECUTA,
        ESCRITA,
        BUSCA_IMED,
        ESCRITA_IMED,
        PARADO
    } t_estado;

    t_estado    r_estado;
    t_estado    w_prox;
    logic [7:0] r_ir;
    logic [7:0] r_pc;
    logic [7:0] r_imediato;
    logic [2:0] w_opcode;
    logic       w_carrega_ir;
    logic       w_carrega_imed;
    logic       w_mem_req;

    assign w_opcode = r_ir[7:5];

    // Next state and state-decoded strobes; ack only counts while requesting.
    always_comb begin
        w_prox         = r_estado;
        w_carrega_ir   = 1'b0;
        w_carrega_imed = 1'b0;
        w_mem_req      = 1'b0;
        reg_escrita    = 1'b0;
        sel_imediato   = 1'b0;
        parado         = 1'b0;
        unique case (r_estado)
            INICIO: begin
                w_prox = BUSCA;
            end
            BUSCA: begin
                w_mem_req = 1'b1;
                if (bus.mem_ack) begin
                    w_carrega_ir = 1'b1;
                    w_prox       = DECODIFICA;
                end
            end
            DECODIFICA: begin
                if (w_opcode <= 3'd5)
                    w_prox = EXECUTA;
                else if (w_opcode == 3'd6)
                    w_prox = BUSCA_IMED;
                else
                    w_prox = PARADO;
            end
            EXECUTA: begin
                w_prox = ESCRITA;
            end
            ESCRITA: begin
                reg_escrita = 1'b1;
                w_prox      = BUSCA;
            end
            BUSCA_IMED: begin
                w_mem_req = 1'b1;
                if (bus.mem_ack) begin
                    w_carrega_imed = 1'b1;
                    w_prox         = ESCRITA_IMED;
                end
            end
            ESCRITA_IMED: begin
                reg_escrita  = 1'b1;
                sel_imediato = 1'b1;
                w_prox       = BUSCA;
            end
            PARADO: begin
                parado = 1'b1;
            end
            default: begin
                w_prox = INICIO;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_estado <= INICIO;
        else
            r_estado <= w_prox;
    end

    // IR, immediate and PC; PC advances on every accepted fetch and wraps.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ir       <= 8'h00;
            r_pc       <= 8'h00;
            r_imediato <= 8'h00;
        end else begin
            if (w_carrega_ir)
                r_ir <= bus.mem_dado;
            if (w_carrega_imed)
                r_imediato <= bus.mem_dado;
            if (w_carrega_ir || w_carrega_imed)
                r_pc <= r_pc + 8'd1;
        end
    end

    assign bus.mem_req      = w_mem_req;
    assign bus.mem_endereco = r_pc;
    assign pc               = r_pc;
    assign imediato         = r_imediato;
    assign reg_rd           = r_ir[4:3];
    assign reg_rs           = r_ir[2:1];
    assign sinal_ula        = (w_opcode <= 3'd5) ? w_opcode : 3'd0;

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: memory model with programmable ack delay and
// a write-back scoreboard filled from the bytes the memory hands out.
module tb_unidade_controle;

    logic       clock;
    logic       reset_n;
    logic [2:0] sinal_ula;
    logic [1:0] reg_rd;
    logic [1:0] reg_rs;
    logic       reg_escrita;
    logic       sel_imediato;
    logic [7:0] imediato;
    logic [7:0] pc;
    logic       parado;

    unidade_controle_if bus ();

    unidade_controle dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus.master),
        .sinal_ula    (sinal_ula),
        .reg_rd       (reg_rd),
        .reg_rs       (reg_rs),
        .reg_escrita  (reg_escrita),
        .sel_imediato (sel_imediato),
        .imediato     (imediato),
        .pc           (pc),
        .parado       (parado)
    );

    typedef struct packed {
        logic [1:0] rd;
        logic [1:0] rs;
        logic [2:0] op;
        logic       sel;
        logic [7:0] imm;
        logic [7:0] pc;
    } t_esp;

    int         n_chk;
    int         n_fail;
    logic [7:0] mem [256];
    int         ack_dly;
    int         wcnt;
    bit         force_ack;
    bit         esp_imed;
    logic [7:0] li_ir;
    t_esp       sb [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responder and reference model of the write-backs it implies.
    always @(negedge clock) begin
        t_esp e;
        logic [7:0] d;
        if (!reset_n) begin
            bus.mem_ack  = 1'b0;
            bus.mem_dado = 8'h00;
            wcnt         = 0;
            esp_imed     = 1'b0;
            sb.delete();
        end else if (bus.mem_req) begin
            if (wcnt >= ack_dly) begin
                d            = mem[bus.mem_endereco];
                bus.mem_ack  = 1'b1;
                bus.mem_dado = d;
                wcnt         = 0;
                e.pc         = bus.mem_endereco + 8'd1;
                if (!esp_imed) begin
                    if (d[7:5] <= 3'd5) begin
                        e.rd  = d[4:3];
                        e.rs  = d[2:1];
                        e.op  = d[7:5];
                        e.sel = 1'b0;
                        e.imm = 8'h00;
                        sb.push_back(e);
                    end else if (d[7:5] == 3'd6) begin
                        esp_imed = 1'b1;
                        li_ir    = d;
                    end
                end else begin
                    esp_imed = 1'b0;
                    e.rd     = li_ir[4:3];
                    e.rs     = li_ir[2:1];
                    e.op     = 3'd0;
                    e.sel    = 1'b1;
                    e.imm    = d;
                    sb.push_back(e);
                end
            end else begin
                bus.mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            bus.mem_ack  = force_ack;
            bus.mem_dado = 8'hFF;
            wcnt         = 0;
        end
    end

    // Scoreboard check on every register-file write strobe.
    always @(negedge clock) begin
        t_esp e;
        if (reset_n && reg_escrita) begin
            if (sb.size() == 0) begin
                chk("sb_vazio", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_rd", reg_rd, e.rd);
                chk("sb_rs", reg_rs, e.rs);
                chk("sb_ula", sinal_ula, e.op);
                chk("sb_sel", sel_imediato, e.sel);
                chk("sb_pc", pc, e.pc);
                if (e.sel)
                    chk("sb_imm", imediato, e.imm);
            end
        end
    end

    task automatic inicia(input logic [7:0] fill, input int dly);
        reset_n   = 1'b0;
        force_ack = 1'b0;
        ack_dly   = dly;
        for (int i = 0; i < 256; i++)
            mem[i] = fill;
        repeat (2) @(negedge clock);
    endtask

    task automatic solta();
        reset_n = 1'b1;
    endtask

    task automatic ciclo(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_req"}, bus.mem_req, 1'b0);
        chk({tag, "_end"}, bus.mem_endereco, 8'h00);
        chk({tag, "_esc"}, reg_escrita, 1'b0);
        chk({tag, "_sel"}, sel_imediato, 1'b0);
        chk({tag, "_par"}, parado, 1'b0);
        chk({tag, "_ula"}, sinal_ula, 3'd0);
        chk({tag, "_rd"}, reg_rd, 2'd0);
        chk({tag, "_rs"}, reg_rs, 2'd0);
        chk({tag, "_imm"}, imediato, 8'h00);
        chk({tag, "_pc"}, pc, 8'h00);
    endtask

    initial begin
        bit achou;
        bit viu_ff;
        bit viu_wrap;
        n_chk  = 0;
        n_fail = 0;
        bus.mem_ack  = 1'b0;
        bus.mem_dado = 8'h00;

        // ADD R1,R0 with zero-wait memory
        inicia(8'hE0, 0);
        chk_reset("rst");
        mem[0] = 8'h48;
        solta();
        #1 chk("add_c0_req", bus.mem_req, 1'b0);
        ciclo(1);
        chk("add_c1_req", bus.mem_req, 1'b1);
        chk("add_c1_end", bus.mem_endereco, 8'h00);
        ciclo(3);
        chk("add_c4_esc", reg_escrita, 1'b1);
        chk("add_c4_sel", sel_imediato, 1'b0);
        chk("add_c4_ula", sinal_ula, 3'd2);
        chk("add_c4_rd", reg_rd, 2'd1);
        chk("add_c4_rs", reg_rs, 2'd0);
        chk("add_c4_pc", pc, 8'h01);
        ciclo(1);
        chk("add_c5_req", bus.mem_req, 1'b1);
        chk("add_c5_end", bus.mem_endereco, 8'h01);

        // LI R2, 0x5A
        inicia(8'hE0, 0);
        mem[0] = 8'hD0;
        mem[1] = 8'h5A;
        solta();
        ciclo(3);
        chk("li_c3_end", bus.mem_endereco, 8'h01);
        ciclo(1);
        chk("li_c4_esc", reg_escrita, 1'b1);
        chk("li_c4_sel", sel_imediato, 1'b1);
        chk("li_c4_imm", imediato, 8'h5A);
        chk("li_c4_rd", reg_rd, 2'd2);
        chk("li_c4_ula", sinal_ula, 3'd0);
        chk("li_c4_pc", pc, 8'h02);

        // ADD with ack delayed by three cycles
        inicia(8'hE0, 3);
        mem[0] = 8'h48;
        solta();
        for (int c = 1; c <= 6; c++) begin
            ciclo(1);
            chk("dly_esc", reg_escrita, 1'b0);
            if (c <= 4) begin
                chk("dly_req", bus.mem_req, 1'b1);
                chk("dly_end", bus.mem_endereco, 8'h00);
                chk("dly_pc0", pc, 8'h00);
            end else begin
                chk("dly_pc1", pc, 8'h01);
            end
        end
        ciclo(1);
        chk("dly_c7_esc", reg_escrita, 1'b1);

        // HALT, then ack forced high
        inicia(8'h00, 0);
        mem[0] = 8'hE0;
        solta();
        ciclo(2);
        chk("halt_c2_par", parado, 1'b0);
        ciclo(1);
        chk("halt_c3_par", parado, 1'b1);
        force_ack = 1'b1;
        for (int c = 0; c < 20; c++) begin
            ciclo(1);
            chk("halt_req", bus.mem_req, 1'b0);
            chk("halt_esc", reg_escrita, 1'b0);
            chk("halt_par", parado, 1'b1);
        end
        chk("halt_pc", pc, 8'h01);
        force_ack = 1'b0;

        // PC wrap: LI at 0xFF takes its immediate from 0x00
        inicia(8'hA0, 0);
        mem[8'hFF] = 8'hC0;
        solta();
        for (int c = 0; c < 10 && pc == 8'h00; c++)
            ciclo(1);
        mem[0] = 8'h33;
        achou    = 1'b0;
        viu_ff   = 1'b0;
        viu_wrap = 1'b0;
        for (int c = 0; c < 1300 && !achou; c++) begin
            ciclo(1);
            if (bus.mem_req && bus.mem_endereco == 8'hFF)
                viu_ff = 1'b1;
            if (viu_ff && bus.mem_req && bus.mem_endereco == 8'h00)
                viu_wrap = 1'b1;
            if (reg_escrita && sel_imediato)
                achou = 1'b1;
        end
        chk("wrap_achou", achou, 1'b1);
        chk("wrap_viu", viu_wrap, 1'b1);
        chk("wrap_imm", imediato, 8'h33);
        chk("wrap_pc", pc, 8'h01);
        chk("wrap_rd", reg_rd, 2'd0);

        // Asynchronous reset in BUSCA_IMED with the ack still pending
        inicia(8'hE0, 5);
        mem[0] = 8'hD0;
        mem[1] = 8'h77;
        solta();
        ciclo(9);
        chk("ar_req", bus.mem_req, 1'b1);
        chk("ar_end", bus.mem_endereco, 8'h01);
        chk("ar_rd", reg_rd, 2'd2);
        #3 reset_n = 1'b0;
        #1 chk_reset("ar");
        ciclo(2);
        ack_dly = 0;
        solta();
        #1 chk("ar_ini_req", bus.mem_req, 1'b0);
        ciclo(1);
        chk("ar_c1_req", bus.mem_req, 1'b1);
        chk("ar_c1_end", bus.mem_endereco, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
